// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one gate-level full adder plus a carry flop,
// processing operands LSB-first and registering sum/carry-out on completion.

module fa (
    output logic s,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy,
    output logic             done
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c;
    logic [WIDTH:0]   acc_ext;

    fa u_fa (
        .s     (fa_s),
        .c_out (fa_c),
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c_in  (carry_q)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        cnt_d   = cnt_q;
        // Widened concat keeps the shift legal when WIDTH == 1.
        acc_ext = {fa_s, acc_q};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                carry_d = fa_c;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                acc_d   = acc_ext[WIDTH:1];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = acc_ext[WIDTH:1];
                    c_out_d = fa_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus random sums
// compared against plain integer addition, for WIDTH=8 and WIDTH=1.

module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8, busy8, done8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0;
    logic [0:0] sum1;
    logic       cout1, busy1, done1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8),
        .sum(sum8), .c_out(cout8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(cin1),
        .sum(sum1), .c_out(cout1), .busy(busy1), .done(done1)
    );

    // Outputs may only move on a done pulse or after a reset edge; done never lasts two cycles.
    logic       rst_seen = 1'b1;
    logic [7:0] prev_sum8 = '0;
    logic       prev_cout8 = 1'b0, prev_done8 = 1'b0;
    logic [0:0] prev_sum1 = '0;
    logic       prev_cout1 = 1'b0, prev_done1 = 1'b0;

    always @(posedge clk) rst_seen <= rst;

    always @(negedge clk) begin
        if (!rst_seen) begin
            if (({cout8, sum8} !== {prev_cout8, prev_sum8}) && !done8) begin
                miscompares++;
                $display("FAIL stable8: sum/c_out moved to %h/%b from %h/%b without done", sum8, cout8, prev_sum8, prev_cout8);
            end
            if (({cout1, sum1} !== {prev_cout1, prev_sum1}) && !done1) begin
                miscompares++;
                $display("FAIL stable1: sum/c_out moved to %b/%b from %b/%b without done", sum1, cout1, prev_sum1, prev_cout1);
            end
            if (done8 && prev_done8) begin
                miscompares++;
                $display("FAIL pulse8: done high 2 cycles, required 1");
            end
            if (done1 && prev_done1) begin
                miscompares++;
                $display("FAIL pulse1: done high 2 cycles, required 1");
            end
        end
        prev_sum8 = sum8; prev_cout8 = cout8; prev_done8 = done8;
        prev_sum1 = sum1; prev_cout1 = cout1; prev_done1 = done1;
    end

    // Stimulus only: launch one WIDTH=8 op and wait (bounded) for done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co,
                        output int busy_cyc, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1; busy_cyc = 0;
        while (!done8 && lat < 40) begin
            if (busy8) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        s = sum8; co = cout8;
    endtask

    task automatic run1(input logic a, input logic b, input logic c,
                        output logic s, output logic co, output int lat);
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = sum1[0]; co = cout1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({sum8, cout8, busy8, done8} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset8: sum/cout/busy/done = %h/%b/%b/%b, required 00/0/0/0", sum8, cout8, busy8, done8);
        end
        vectors++;
        if ({sum1, cout1, busy1, done1} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset1: sum/cout/busy/done = %b/%b/%b/%b, required 0/0/0/0", sum1, cout1, busy1, done1);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] s; logic co; int bc, lat;
        run8(8'h5A, 8'h3C, 1'b0, s, co, bc, lat);
        vectors++;
        if (bc !== 8) begin
            miscompares++;
            $display("FAIL basic_busy: busy cycles %0d, required 8", bc);
        end
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("FAIL basic_latency: done after %0d cycles, required 9", lat);
        end
        vectors++;
        if ({co, s} !== 9'h096) begin
            miscompares++;
            $display("FAIL basic_sum: c_out/sum %b/%h, required 0/96", co, s);
        end
    endtask

    task automatic test_carry;
        logic [7:0] s; logic co; int bc, lat;
        run8(8'hFF, 8'h01, 1'b0, s, co, bc, lat);
        vectors++;
        if ({co, s} !== 9'h100) begin
            miscompares++;
            $display("FAIL carry_ff01: c_out/sum %b/%h, required 1/00", co, s);
        end
        run8(8'hFF, 8'h00, 1'b1, s, co, bc, lat);
        vectors++;
        if ({co, s} !== 9'h100) begin
            miscompares++;
            $display("FAIL carry_ff00c: c_out/sum %b/%h, required 1/00", co, s);
        end
        run8(8'hFF, 8'hFF, 1'b1, s, co, bc, lat);
        vectors++;
        if ({co, s} !== 9'h1FF) begin
            miscompares++;
            $display("FAIL carry_max: c_out/sum %b/%h, required 1/ff", co, s);
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
        lat = 4;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("FAIL ignore_latency: done after %0d cycles, required 9", lat);
        end
        vectors++;
        if ({cout8, sum8} !== 9'h033) begin
            miscompares++;
            $display("FAIL ignore_sum: c_out/sum %b/%h, required 0/33", cout8, sum8);
        end
        @(negedge clk);
        vectors++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_idle: busy/done %b/%b after op, required 0/0", busy8, done8);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] s; logic co; int bc, lat; int seen_done;
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy8, done8, cout8, sum8} !== 11'b0) begin
            miscompares++;
            $display("FAIL rstmid_state: busy/done/c_out/sum %b/%b/%b/%h, required 0/0/0/00", busy8, done8, cout8, sum8);
        end
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen_done++;
        end
        vectors++;
        if (seen_done !== 0) begin
            miscompares++;
            $display("FAIL rstmid_nodone: %0d busy/done cycles after abort, required 0", seen_done);
        end
        run8(8'h7E, 8'h0B, 1'b1, s, co, bc, lat);
        vectors++;
        if ({co, s} !== 9'h08A || lat !== 9) begin
            miscompares++;
            $display("FAIL rstmid_restart: c_out/sum %b/%h lat %0d, required 0/8a lat 9", co, s, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] ao[3] = '{8'hC3, 8'h01, 8'h9F};
        logic [7:0] bo[3] = '{8'h4D, 8'hFE, 8'h60};
        logic       co[3] = '{1'b1, 1'b1, 1'b0};
        logic [8:0] exp;
        int idx = 0, cyc = 0, last = 0;
        @(negedge clk);
        a8 = ao[0]; b8 = bo[0]; cin8 = co[0]; start8 = 1'b1;
        while (idx < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done8) begin
                exp = {1'b0, ao[idx]} + {1'b0, bo[idx]} + {8'b0, co[idx]};
                vectors++;
                if ({cout8, sum8} !== exp) begin
                    miscompares++;
                    $display("FAIL b2b_sum%0d: c_out/sum %h, required %h", idx, {cout8, sum8}, exp);
                end
                vectors++;
                if (cyc - last !== 9) begin
                    miscompares++;
                    $display("FAIL b2b_period%0d: %0d cycles between pulses, required 9", idx, cyc - last);
                end
                last = cyc;
                idx++;
                if (idx < 3) begin
                    a8 = ao[idx]; b8 = bo[idx]; cin8 = co[idx];
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        start8 = 1'b0;
        vectors++;
        if (idx !== 3) begin
            miscompares++;
            $display("FAIL b2b_count: %0d ops completed, required 3", idx);
        end
    endtask

    task automatic test_random8;
        logic [7:0] a, b, s; logic c, co; int bc, lat; int exp;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            run8(a, b, c, s, co, bc, lat);
            exp = int'(a) + int'(b) + int'(c);
            vectors++;
            if (lat !== 9 || int'({co, s}) !== exp) begin
                miscompares++;
                $display("FAIL rand8: %h+%h+%b got %h lat %0d, required %h lat 9", a, b, c, {co, s}, lat, exp[8:0]);
            end
        end
    endtask

    task automatic test_random1;
        logic a, b, c, s, co; int lat; int exp;
        for (int i = 0; i < 1000; i++) begin
            a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
            run1(a, b, c, s, co, lat);
            exp = int'(a) + int'(b) + int'(c);
            vectors++;
            if (lat !== 2 || int'({co, s}) !== exp) begin
                miscompares++;
                $display("FAIL rand1: %b+%b+%b got %b%b lat %0d, required %0d lat 2", a, b, c, co, s, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        test_random8;
        test_random1;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
